pkg_fdma_engine: RTL and testbench
==================================

PKG_FDMA_ENGINE -- requirements
Module: pkg_fdma_engine

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, byte-address width; DATA_W, default 128, beat width; MAX_BEATS, default 256, largest legal pkg size in beats.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-003 ports: ui_clk  in  1  sole clock; ui_rst  in  1  synchronous active-high reset.
REQ-004 pkg write side: pkg_wr_areq in 1 request pulse; pkg_wr_addr in 32 byte addr; pkg_wr_size in 32 beats; pkg_wr_data in DATA_W (FWFT source); pkg_wr_en out 1 beat consumed; pkg_wr_last out 1 done pulse.
REQ-005 pkg read side: pkg_rd_areq in 1; pkg_rd_addr in 32; pkg_rd_size in 32; pkg_rd_en out 1 beat valid; pkg_rd_data out DATA_W; pkg_rd_last out 1 done pulse.
REQ-006 AXI4 write master: awaddr out ADDR_W; awlen out 8; awsize out 3; awburst out 2; awvalid out 1; awready in 1; wdata out DATA_W; wstrb out DATA_W/8; wlast out 1; wvalid out 1; wready in 1; bresp in 2; bvalid in 1; bready out 1.
REQ-007 AXI4 read master: araddr out ADDR_W; arlen out 8; arsize out 3; arburst out 2; arvalid out 1; arready in 1; rdata in DATA_W; rresp in 2; rlast in 1; rvalid in 1; rready out 1.
REQ-008 status: wr_busy out 1; rd_busy out 1; err out 4 sticky {req_overrun, bad_size, wr_resp, rd_resp/len}.

Function
REQ-009 write and read channels SHALL run independently and concurrently; simultaneous areq on both SHALL start both in the same cycle.
REQ-010 write FSM states W_IDLE, W_ADDR, W_DATA, W_RESP; read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-011 in *_IDLE, areq SHALL latch addr and size; next state *_ADDR; busy rises the cycle after areq.
REQ-012 size 0 or > MAX_BEATS SHALL not issue AXI traffic: err[2] set, *_last pulsed one cycle later, FSM returns to idle.
REQ-013 areq while the channel is not idle SHALL be ignored and set err[3].
REQ-014 awlen/arlen = size-1 (low 8 bits); awsize/arsize = log2(DATA_W/8); burst INCR (2'b01); wstrb all ones.
REQ-015 *_ADDR: valid held high, address stable until ready; on valid&ready go to *_DATA.
REQ-016 W_DATA: wvalid=1, wdata=pkg_wr_data combinationally, pkg_wr_en = wvalid&wready, beat counter increments per handshake, wlast high when counter == size-1; after last handshake go to W_RESP.
REQ-017 W_RESP: bready=1; on bvalid pulse pkg_wr_last one cycle, set err[1] if bresp != 0, go to W_IDLE.
REQ-018 R_DATA: rready=1; pkg_rd_en = rvalid, pkg_rd_data = rdata same cycle; pkg_rd_last coincident with beat carrying rlast; then R_IDLE.
REQ-019 err[0] SHALL set if rresp != 0 on any beat or if rlast arrives at beat count != size-1.
REQ-020 new request SHALL be accepted the cycle after *_last (back-to-back capable).
REQ-021 wvalid SHALL not depend on wready; AXI valid signals never drop before handshake.
REQ-022 address arithmetic unmodified; callers guarantee no 4 KB crossing (256x16 B aligned).

Reset
REQ-023 ui_rst SHALL force: FSMs idle, all valid/en/last/ready outputs 0, bready 0, counters 0, err 0, busy 0, addr/len registers 0.
REQ-024 reset mid-burst SHALL abort immediately without *_last pulse; reset is applied together with the interconnect reset.

Structure
REQ-025 shared package pkg_fdma_pkg SHALL hold FSM state encodings, AXI burst/resp constants, MAX_BEATS default, err bit indices.
REQ-026 no sub-module; both channel FSMs live in pkg_fdma_engine.

Verification
REQ-027 write addr 0x0000_1000 size 256, awready after 3 cycles, wready always 1 -> awlen 0xFF, 256 pkg_wr_en, wlast on beat 255, pkg_wr_last one cycle after bvalid.
REQ-028 read addr 0x0000_2000 size 256 with rvalid toggled 50% -> 256 pkg_rd_en matching rdata order, pkg_rd_last on rlast beat, err 0.
REQ-029 write and read areq same cycle, sizes 16 -> both channels complete independently, no data crossover.
REQ-030 pkg_wr_areq with size 0, then size 300 -> no awvalid, err[2]=1, two pkg_wr_last pulses.
REQ-031 bresp 2'b10 on write, rresp 2'b10 on read beat 5 -> err[1]=1, err[0]=1, both last pulses still issued.
REQ-032 ui_rst at read beat 100 of 256 -> next cycle all outputs 0, no pkg_rd_last; new request after reset completes normally.

Source files
------------

// File: rtl/pkg_fdma_pkg.sv
// ---------------------------------------------------------------------------
// pkg_fdma_pkg
// Shared definitions for the packet DMA engine: channel FSM state encodings,
// AXI burst/response constants, the default packet size limit, and the bit
// positions inside the sticky error vector.
// ---------------------------------------------------------------------------
package pkg_fdma_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int MAX_BEATS_DEFAULT = 256;

    // Sticky error vector bit positions
    localparam int ERR_REQ_OVERRUN = 3;
    localparam int ERR_BAD_SIZE    = 2;
    localparam int ERR_WR_RESP     = 1;
    localparam int ERR_RD          = 0;

    // A packet is legal when it has at least one beat and fits in one burst.
    function automatic logic size_ok(input logic [31:0] size, input int max_beats);
        return (size != 32'd0) && (size <= 32'(max_beats));
    endfunction

endpackage

// File: rtl/pkg_fdma_engine.sv
// ---------------------------------------------------------------------------
// pkg_fdma_engine
// Moves fixed-size packets between a FWFT packet interface and AXI4 memory.
// Write channel: pkg_wr_* request -> one AW burst, W beats pulled from
// pkg_wr_data, B response -> pkg_wr_last pulse.
// Read channel: pkg_rd_* request -> one AR burst, R beats forwarded on
// pkg_rd_en/pkg_rd_data, pkg_rd_last on the rlast beat.
// The two channels are fully independent.
// Ports:
//   ui_clk, ui_rst            clock, synchronous active-high reset
//   pkg_wr_* / pkg_rd_*       packet request and data interfaces
//   aw*/w*/b*, ar*/r*         AXI4 write / read master
//   wr_busy, rd_busy          channel not idle
//   err[3:0]                  sticky {req_overrun, bad_size, wr_resp, rd_resp/len}
// ---------------------------------------------------------------------------
module pkg_fdma_engine
    import pkg_fdma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    // packet write side
    input  logic                pkg_wr_areq,
    input  logic [31:0]         pkg_wr_addr,
    input  logic [31:0]         pkg_wr_size,
    input  logic [DATA_W-1:0]   pkg_wr_data,
    output logic                pkg_wr_en,
    output logic                pkg_wr_last,
    // packet read side
    input  logic                pkg_rd_areq,
    input  logic [31:0]         pkg_rd_addr,
    input  logic [31:0]         pkg_rd_size,
    output logic                pkg_rd_en,
    output logic [DATA_W-1:0]   pkg_rd_data,
    output logic                pkg_rd_last,
    // AXI4 write master
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // AXI4 read master
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // status
    output logic                wr_busy,
    output logic                rd_busy,
    output logic [3:0]          err
);

    localparam int               CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       BEAT_SIZE = 3'($clog2(DATA_W / 8));

    // write channel state
    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              awvalid_q, awvalid_d;
    logic [CNT_W-1:0]  w_size_q, w_size_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
    logic              wr_last_q, wr_last_d;
    logic [3:0]        wr_err_set;
    logic              wlast_int;

    // read channel state
    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              arvalid_q, arvalid_d;
    logic [CNT_W-1:0]  r_size_q, r_size_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic              rd_bad_last_q, rd_bad_last_d;
    logic [3:0]        rd_err_set;

    logic [3:0]        err_q, err_d;

    assign wlast_int = (w_state_q == W_DATA) && (w_cnt_q == (w_size_q - CNT_ONE));

    // ---------------- write channel next state ----------------
    always_comb begin
        w_state_d  = w_state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awvalid_d  = awvalid_q;
        w_size_d   = w_size_q;
        w_cnt_d    = w_cnt_q;
        wr_last_d  = 1'b0;
        wr_err_set = 4'b0000;
        case (w_state_q)
            W_IDLE: begin
                if (pkg_wr_areq) begin
                    if (size_ok(pkg_wr_size, MAX_BEATS)) begin
                        awaddr_d  = pkg_wr_addr[ADDR_W-1:0];
                        awlen_d   = pkg_wr_size[7:0] - 8'd1;
                        w_size_d  = pkg_wr_size[CNT_W-1:0];
                        w_cnt_d   = '0;
                        awvalid_d = 1'b1;
                        w_state_d = W_ADDR;
                    end else begin
                        // illegal size: no bus traffic, just report and complete
                        wr_err_set[ERR_BAD_SIZE] = 1'b1;
                        wr_last_d = 1'b1;
                    end
                end
            end
            W_ADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready) begin
                    w_cnt_d = w_cnt_q + CNT_ONE;
                    if (wlast_int) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    wr_last_d = 1'b1;
                    if (bresp != AXI_RESP_OKAY) begin
                        wr_err_set[ERR_WR_RESP] = 1'b1;
                    end
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (pkg_wr_areq && (w_state_q != W_IDLE)) begin
            wr_err_set[ERR_REQ_OVERRUN] = 1'b1;
        end
    end

    // ---------------- read channel next state ----------------
    always_comb begin
        r_state_d     = r_state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        r_size_d      = r_size_q;
        r_cnt_d       = r_cnt_q;
        rd_bad_last_d = 1'b0;
        rd_err_set    = 4'b0000;
        case (r_state_q)
            R_IDLE: begin
                if (pkg_rd_areq) begin
                    if (size_ok(pkg_rd_size, MAX_BEATS)) begin
                        araddr_d  = pkg_rd_addr[ADDR_W-1:0];
                        arlen_d   = pkg_rd_size[7:0] - 8'd1;
                        r_size_d  = pkg_rd_size[CNT_W-1:0];
                        r_cnt_d   = '0;
                        arvalid_d = 1'b1;
                        r_state_d = R_ADDR;
                    end else begin
                        rd_err_set[ERR_BAD_SIZE] = 1'b1;
                        rd_bad_last_d = 1'b1;
                    end
                end
            end
            R_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    r_cnt_d = r_cnt_q + CNT_ONE;
                    if (rresp != AXI_RESP_OKAY) begin
                        rd_err_set[ERR_RD] = 1'b1;
                    end
                    // slave ended the burst early or late
                    if (rlast) begin
                        if (r_cnt_q != (r_size_q - CNT_ONE)) begin
                            rd_err_set[ERR_RD] = 1'b1;
                        end
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (pkg_rd_areq && (r_state_q != R_IDLE)) begin
            rd_err_set[ERR_REQ_OVERRUN] = 1'b1;
        end
    end

    assign err_d = err_q | wr_err_set | rd_err_set;

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            w_state_q     <= W_IDLE;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awvalid_q     <= 1'b0;
            w_size_q      <= '0;
            w_cnt_q       <= '0;
            wr_last_q     <= 1'b0;
            r_state_q     <= R_IDLE;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            r_size_q      <= '0;
            r_cnt_q       <= '0;
            rd_bad_last_q <= 1'b0;
            err_q         <= '0;
        end else begin
            w_state_q     <= w_state_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awvalid_q     <= awvalid_d;
            w_size_q      <= w_size_d;
            w_cnt_q       <= w_cnt_d;
            wr_last_q     <= wr_last_d;
            r_state_q     <= r_state_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            r_size_q      <= r_size_d;
            r_cnt_q       <= r_cnt_d;
            rd_bad_last_q <= rd_bad_last_d;
            err_q         <= err_d;
        end
    end

    // write outputs
    assign awaddr      = awaddr_q;
    assign awlen       = awlen_q;
    assign awsize      = BEAT_SIZE;
    assign awburst     = AXI_BURST_INCR;
    assign awvalid     = awvalid_q;
    assign wvalid      = (w_state_q == W_DATA);
    assign wdata       = pkg_wr_data;
    assign wstrb       = {(DATA_W/8){1'b1}};
    assign wlast       = wlast_int;
    assign pkg_wr_en   = wvalid & wready;
    assign bready      = (w_state_q == W_RESP);
    assign pkg_wr_last = wr_last_q;
    assign wr_busy     = (w_state_q != W_IDLE);

    // read outputs
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arsize      = BEAT_SIZE;
    assign arburst     = AXI_BURST_INCR;
    assign arvalid     = arvalid_q;
    assign rready      = (r_state_q == R_DATA);
    assign pkg_rd_en   = rready & rvalid;
    assign pkg_rd_data = rdata;
    // normal completion is on the rlast beat; illegal sizes complete a cycle after the request
    assign pkg_rd_last = (pkg_rd_en & rlast) | rd_bad_last_q;
    assign rd_busy     = (r_state_q != R_IDLE);

    assign err = err_q;

endmodule

// File: tb/tb_pkg_fdma_engine.sv
// ---------------------------------------------------------------------------
// tb_pkg_fdma_engine
// Directed bench for pkg_fdma_engine: single write burst, single read burst
// with throttled rvalid, concurrent channels, illegal sizes, error responses,
// early rlast, request overrun and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_pkg_fdma_engine;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic                ui_clk = 1'b0;
    logic                ui_rst;
    logic                pkg_wr_areq;
    logic [31:0]         pkg_wr_addr;
    logic [31:0]         pkg_wr_size;
    logic [DATA_W-1:0]   pkg_wr_data;
    logic                pkg_wr_en;
    logic                pkg_wr_last;
    logic                pkg_rd_areq;
    logic [31:0]         pkg_rd_addr;
    logic [31:0]         pkg_rd_size;
    logic                pkg_rd_en;
    logic [DATA_W-1:0]   pkg_rd_data;
    logic                pkg_rd_last;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic                wr_busy;
    logic                rd_busy;
    logic [3:0]          err;

    always #5 ui_clk = ~ui_clk;

    pkg_fdma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(256)) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .pkg_wr_areq(pkg_wr_areq), .pkg_wr_addr(pkg_wr_addr), .pkg_wr_size(pkg_wr_size),
        .pkg_wr_data(pkg_wr_data), .pkg_wr_en(pkg_wr_en), .pkg_wr_last(pkg_wr_last),
        .pkg_rd_areq(pkg_rd_areq), .pkg_rd_addr(pkg_rd_addr), .pkg_rd_size(pkg_rd_size),
        .pkg_rd_en(pkg_rd_en), .pkg_rd_data(pkg_rd_data), .pkg_rd_last(pkg_rd_last),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .err(err)
    );

    int errors = 0;
    int checks = 0;

    // results of run_pair and the inline bursts
    int wbeat, rbeat, dmis, wlast_bad, wl, rl;
    int en_cnt, wl_cnt, wl_at;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic do_reset();
        ui_rst = 1'b1;
        cyc();
        cyc();
        ui_rst = 1'b0;
    endtask

    // Both channels requested in the same cycle, slave responds with
    // independent throttling. rbad: read beat carrying SLVERR (-1 none);
    // rl_at: read beat on which rlast is driven.
    task automatic run_pair(input int wn, input int rn, input logic [1:0] br,
                            input int rbad, input int rl_at);
        logic b_done, r_done;
        wbeat = 0; rbeat = 0; dmis = 0; wlast_bad = 0; wl = 0; rl = 0;
        b_done = 1'b0; r_done = 1'b0;
        pkg_wr_addr = 32'h0000_3000; pkg_wr_size = 32'(wn);
        pkg_rd_addr = 32'h0000_4000; pkg_rd_size = 32'(rn);
        pkg_wr_areq = 1'b1; pkg_rd_areq = 1'b1;
        cyc();
        pkg_wr_areq = 1'b0; pkg_rd_areq = 1'b0;
        #1;
        chk("pair_valid_busy", {awvalid, arvalid, wr_busy, rd_busy}, 4'hF);
        chk("pair_awlen", awlen, 128'(wn - 1));
        chk("pair_arlen", arlen, 128'(rn - 1));
        cyc();
        awready = 1'b1; arready = 1'b1;
        cyc();
        awready = 1'b0; arready = 1'b0;
        for (int c = 0; c < 400 && !(wl > 0 && rl > 0); c++) begin
            wready      = ((c % 3) != 2);
            pkg_wr_data = 128'hA000_0000 + 128'(wbeat);
            bvalid      = bready && !b_done;
            bresp       = br;
            rvalid      = !r_done && ((c % 2) == 0);
            rdata       = 128'hB000_0000 + 128'(rbeat);
            rresp       = (rbeat == rbad) ? 2'b10 : 2'b00;
            rlast       = (rbeat == rl_at);
            #1;
            if (pkg_wr_en) begin
                if (wdata !== 128'hA000_0000 + 128'(wbeat)) dmis++;
                if (wlast !== (wbeat == wn - 1)) wlast_bad++;
                wbeat++;
            end
            if (pkg_rd_en) begin
                if (pkg_rd_data !== 128'hB000_0000 + 128'(rbeat)) dmis++;
                if (pkg_rd_last !== rlast) dmis++;
                if (rlast) r_done = 1'b1;
                rbeat++;
            end
            if (bvalid) b_done = 1'b1;
            if (pkg_wr_last) wl++;
            if (pkg_rd_last) rl++;
            cyc();
        end
        wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0; rlast = 1'b0;
        rresp = 2'b00; bresp = 2'b00;
        #1;
        chk("pair_idle_after", {wr_busy, rd_busy}, 2'b00);
        cyc();
    endtask

    initial begin
        ui_rst = 1'b1;
        pkg_wr_areq = 0; pkg_wr_addr = 0; pkg_wr_size = 0; pkg_wr_data = 0;
        pkg_rd_areq = 0; pkg_rd_addr = 0; pkg_rd_size = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;

        // ---- reset state ----
        do_reset();
        #1;
        chk("reset_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, pkg_wr_en,
                           pkg_wr_last, pkg_rd_en, pkg_rd_last, wr_busy, rd_busy}, 12'h000);
        chk("reset_err", err, 4'h0);
        chk("reset_len_addr", {awlen, arlen, awaddr, araddr}, 80'h0);
        chk("static_size_burst", {awsize, awburst, arsize, arburst}, 10'b100_01_100_01);
        chk("wstrb", wstrb, 16'hFFFF);
        cyc();

        // ---- 256-beat write, awready after 3 cycles, wready always high ----
        pkg_wr_addr = 32'h0000_1000; pkg_wr_size = 32'd256; pkg_wr_areq = 1'b1;
        #1;
        chk("wr_busy_not_yet", wr_busy, 1'b0);
        cyc();
        pkg_wr_areq = 1'b0;
        #1;
        chk("wr_addr_phase", {awvalid, wr_busy}, 2'b11);
        chk("wr_awaddr", awaddr, 32'h0000_1000);
        chk("wr_awlen", awlen, 8'hFF);
        cyc();
        #1;
        chk("awvalid_hold1", awvalid, 1'b1);
        cyc();
        awready = 1'b1;
        #1;
        chk("awvalid_hold2", {awvalid, wvalid}, 2'b10);
        cyc();
        awready = 1'b0; wready = 1'b1;
        en_cnt = 0; wl_cnt = 0; wl_at = -1; dmis = 0;
        for (int i = 0; i < 256; i++) begin
            pkg_wr_data = {4{32'(i) + 32'h5A00_0000}};
            #1;
            if (pkg_wr_en) en_cnt++;
            if (wdata !== {4{32'(i) + 32'h5A00_0000}}) dmis++;
            if (wlast) begin
                wl_cnt++;
                wl_at = i;
            end
            cyc();
        end
        wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("wr_resp_phase", {bready, wvalid, pkg_wr_last, wr_busy}, 4'b1001);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("wr_last_after_b", {pkg_wr_last, wr_busy, bready}, 3'b100);
        cyc();
        #1;
        chk("wr_last_one_cycle", pkg_wr_last, 1'b0);
        chk("wr_en_count", en_cnt, 256);
        chk("wr_wlast_count", wl_cnt, 1);
        chk("wr_wlast_beat", wl_at, 255);
        chk("wr_data_mis", dmis, 0);
        chk("wr_err", err, 4'h0);
        cyc();

        // ---- 256-beat read, rvalid 50% ----
        pkg_rd_addr = 32'h0000_2000; pkg_rd_size = 32'd256; pkg_rd_areq = 1'b1;
        #1;
        chk("rd_busy_not_yet", rd_busy, 1'b0);
        cyc();
        pkg_rd_areq = 1'b0;
        #1;
        chk("rd_addr_phase", {arvalid, rd_busy, rready}, 3'b110);
        chk("rd_araddr", araddr, 32'h0000_2000);
        chk("rd_arlen", arlen, 8'hFF);
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rbeat = 0; dmis = 0; rl = 0;
        for (int c = 0; c < 1200 && rbeat < 256; c++) begin
            rvalid = ((c % 2) == 0);
            rdata  = 128'hC0DE_0000 + 128'(rbeat);
            rlast  = rvalid && (rbeat == 255);
            #1;
            if (rready !== 1'b1) dmis++;
            if (pkg_rd_en !== rvalid) dmis++;
            if (pkg_rd_last !== rlast) dmis++;
            if (pkg_rd_last) rl++;
            if (rvalid) begin
                if (pkg_rd_data !== 128'hC0DE_0000 + 128'(rbeat)) dmis++;
                rbeat++;
            end
            cyc();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("rd_beats", rbeat, 256);
        chk("rd_mis", dmis, 0);
        chk("rd_last_count", rl, 1);
        chk("rd_idle", {rd_busy, rready}, 2'b00);
        chk("rd_err", err, 4'h0);
        cyc();

        // ---- concurrent 16-beat write and read ----
        run_pair(16, 16, 2'b00, -1, 15);
        chk("conc_wbeats", wbeat, 16);
        chk("conc_rbeats", rbeat, 16);
        chk("conc_data_mis", dmis, 0);
        chk("conc_wlast_bad", wlast_bad, 0);
        chk("conc_lasts", {wl[7:0], rl[7:0]}, 16'h0101);
        chk("conc_err", err, 4'h0);

        // ---- illegal sizes ----
        pkg_wr_size = 32'd0; pkg_wr_areq = 1'b1;
        cyc();
        pkg_wr_areq = 1'b0;
        #1;
        chk("size0_resp", {awvalid, wr_busy, pkg_wr_last}, 3'b001);
        chk("size0_err", err, 4'b0100);
        cyc();
        #1;
        chk("size0_last_drop", pkg_wr_last, 1'b0);
        cyc();
        pkg_wr_size = 32'd300; pkg_rd_size = 32'd300;
        pkg_wr_areq = 1'b1; pkg_rd_areq = 1'b1;
        cyc();
        pkg_wr_areq = 1'b0; pkg_rd_areq = 1'b0;
        #1;
        chk("size300_resp", {awvalid, arvalid, wr_busy, rd_busy, pkg_wr_last, pkg_rd_last}, 6'b000011);
        chk("size300_err", err, 4'b0100);
        cyc();
        #1;
        chk("size300_last_drop", {pkg_wr_last, pkg_rd_last, awvalid}, 3'b000);
        cyc();

        // ---- SLVERR on B and on read beat 5 ----
        do_reset();
        run_pair(2, 8, 2'b10, 5, 7);
        chk("resp_err", err, 4'b0011);
        chk("resp_lasts", {wl[7:0], rl[7:0]}, 16'h0101);
        chk("resp_beats", {wbeat[7:0], rbeat[7:0]}, 16'h0208);
        chk("resp_data_mis", dmis, 0);

        // ---- rlast arrives early ----
        do_reset();
        run_pair(4, 4, 2'b00, -1, 2);
        chk("early_rlast_err", err, 4'b0001);
        chk("early_rlast_beats", rbeat, 3);
        chk("early_rlast_last", rl, 1);

        // ---- overrun request, then reset at read beat 100 ----
        do_reset();
        pkg_rd_addr = 32'h0000_5000; pkg_rd_size = 32'd256; pkg_rd_areq = 1'b1;
        cyc();
        pkg_rd_areq = 1'b0;
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rbeat = 0; rl = 0;
        for (int c = 0; c < 400 && rbeat < 100; c++) begin
            rvalid = 1'b1;
            rdata  = 128'hD000_0000 + 128'(rbeat);
            rlast  = 1'b0;
            pkg_rd_areq = (rbeat == 50);
            #1;
            if (pkg_rd_last) rl++;
            if (pkg_rd_en) rbeat++;
            cyc();
        end
        pkg_rd_areq = 1'b0;
        ui_rst = 1'b1;
        rvalid = 1'b1;
        #1;
        chk("pre_reset_beats", rbeat, 100);
        chk("overrun_err", err, 4'b1000);
        chk("pre_reset_busy", rd_busy, 1'b1);
        cyc();
        ui_rst = 1'b0;
        rvalid = 1'b0;
        #1;
        chk("midreset_ctrl", {awvalid, wvalid, bready, arvalid, rready, pkg_wr_en,
                              pkg_wr_last, pkg_rd_en, pkg_rd_last, wr_busy, rd_busy}, 11'h000);
        chk("midreset_err_len", {err, arlen, araddr}, 44'h0);
        chk("midreset_no_last", rl, 0);
        cyc();
        run_pair(4, 4, 2'b00, -1, 3);
        chk("post_reset_beats", {wbeat[7:0], rbeat[7:0]}, 16'h0404);
        chk("post_reset_lasts", {wl[7:0], rl[7:0]}, 16'h0101);
        chk("post_reset_mis", dmis + wlast_bad, 0);
        chk("post_reset_err", err, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard stop if the sequence above ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
